// File: rtl/hex_radix_converter_if.sv
// Handshake and result bundle for hex_radix_converter.
// master drives start/hex_in; slave is the converter.
interface hex_radix_converter_if #(
   parameter int HEX_DIGITS = 4,
   parameter int DEC_DIGITS = 5
);
   localparam int WIDTH      = 4 * HEX_DIGITS;
   localparam int OCT_DIGITS = (WIDTH + 2) / 3;

   logic                      start;
   logic [WIDTH-1:0]          hex_in;
   logic                      ready;
   logic                      busy;
   logic                      done;
   logic [WIDTH-1:0]          binary_out;
   logic [4*DEC_DIGITS-1:0]   bcd_out;
   logic [3*OCT_DIGITS-1:0]   octal_out;
   logic                      overflow;

   modport master (
      output start, hex_in,
      input  ready, busy, done, binary_out, bcd_out, octal_out, overflow
   );

   modport slave (
      input  start, hex_in,
      output ready, busy, done, binary_out, bcd_out, octal_out, overflow
   );
endinterface

// File: rtl/hex_radix_converter.sv
// Serial hex -> binary/BCD/octal converter using double-dabble, one bit per clock.
// Define OCTAL_OUT_EN to build the octal output; otherwise octal_out is tied to zero.
module hex_radix_converter #(
   parameter int HEX_DIGITS = 4,
   parameter int DEC_DIGITS = 5
) (
   input logic                  clk,
   input logic                  rst,
   hex_radix_converter_if.slave bus
);
   localparam int WIDTH  = 4 * HEX_DIGITS;
   localparam int BCD_W  = 4 * DEC_DIGITS;
   localparam int OCT_W  = 3 * ((WIDTH + 2) / 3);
   localparam int CNT_W  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   cap;
   logic [WIDTH-1:0]   sreg;
   logic [BCD_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_sticky;
   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_nxt;
   logic [WIDTH-1:0]   sreg_nxt;
   logic               carry_out;
   logic               ovf_nxt;
   logic               last_shift;
   logic [WIDTH-1:0]   bin_r;
   logic [BCD_W-1:0]   bcd_r;
   logic               ovf_r;
   logic               done_r;

   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < DEC_DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] a, input logic ovf);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < DEC_DIGITS; i++) begin
         if (ovf) r[4*i +: 4] = 4'h9;
      end
      return r;
   endfunction

   // A set bit leaving the top digit means the value doubled past 10^DEC_DIGITS-1.
   assign acc_adj    = add3_digits(acc);
   assign carry_out  = acc_adj[BCD_W-1];
   assign acc_nxt    = {acc_adj[BCD_W-2:0], sreg[WIDTH-1]};
   assign sreg_nxt   = {sreg[WIDTH-2:0], 1'b0};
   assign ovf_nxt    = ovf_sticky | carry_out;
   assign last_shift = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      bus.ready = 1'b0;
      bus.busy  = 1'b1;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            bus.busy  = 1'b0;
            if (bus.start) state_nxt = SHIFT;
         end
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cap        <= '0;
         sreg       <= '0;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         bin_r      <= '0;
         bcd_r      <= '0;
         ovf_r      <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  cap        <= bus.hex_in;
                  sreg       <= bus.hex_in;
                  acc        <= '0;
                  cnt        <= '0;
                  ovf_sticky <= 1'b0;
               end
            end
            SHIFT: begin
               sreg       <= sreg_nxt;
               acc        <= acc_nxt;
               cnt        <= cnt + CNT_W'(1);
               ovf_sticky <= ovf_nxt;
               // Results land on the edge entering DONE so done and data align.
               if (last_shift) begin
                  done_r <= 1'b1;
                  bin_r  <= cap;
                  bcd_r  <= saturate(acc_nxt, ovf_nxt);
                  ovf_r  <= ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.done       = done_r;
   assign bus.binary_out = bin_r;
   assign bus.bcd_out    = bcd_r;
   assign bus.overflow   = ovf_r;

`ifdef OCTAL_OUT_EN
   logic [OCT_W-1:0] oct_r;

   // Octal regroup of the captured word is its zero-extension read in 3-bit fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         oct_r <= '0;
      end else if (last_shift) begin
         oct_r <= OCT_W'(cap);
      end
   end

   assign bus.octal_out = oct_r;
`else
   assign bus.octal_out = '0;
`endif
endmodule

// File: doc/hex_radix_converter.md
# hex_radix_converter

Sequential, parametrised hexadecimal-to-radix converter. It accepts a hex word of configurable digit count and produces registered binary, BCD-decimal and octal representations of that word. Decimal conversion is serial shift-and-add-3 (double-dabble), one input bit per clock. The block sits between register/keypad capture logic and display drivers wherever a multi-digit hex value must be shown in another radix.

## Interface
Parameters:
- HEX_DIGITS, 4, number of hex input digits; WIDTH = 4*HEX_DIGITS.
- DEC_DIGITS, 5, number of BCD output digits; values ≥ 10^DEC_DIGITS flag overflow.
- OCT_DIGITS (localparam), ceil(WIDTH/3), number of octal output digits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of hex_in; honoured only when ready=1.
- hex_in  in  WIDTH  value to convert; sampled on the accepting edge only.
- ready  out  1  block idle, start will be accepted.
- busy  out  1  conversion in progress (SHIFT or DONE).
- done  out  1  one-cycle pulse, results valid and updated.
- binary_out  out  WIDTH  captured input value.
- bcd_out  out  4*DEC_DIGITS  BCD digits, least-significant digit in bits [3:0].
- octal_out  out  3*OCT_DIGITS  octal digits, zero-extended, least-significant digit in bits [2:0].
- overflow  out  1  last result exceeded 10^DEC_DIGITS−1.

## Operation
- FSM states: IDLE, SHIFT, DONE. ready = (state==IDLE); busy = !ready.
- IDLE: on start=1, capture hex_in into the shift register and clear the BCD accumulator and bit counter; go to SHIFT.
- SHIFT: each cycle, add 3 to every accumulator digit ≥5, then shift {accumulator, shift register} left by 1. A 1 shifted out of the top BCD digit sets the internal overflow sticky bit. After exactly WIDTH shifts, go to DONE.
- DONE: registers binary_out, bcd_out, octal_out and overflow and asserts done for one cycle. The next state is IDLE.
- Overflow: bcd_out saturates to all 9s (every digit 4'h9) and overflow=1. binary_out and octal_out remain exact.
- octal_out is derived by regrouping the captured value into 3-bit fields.
- Outputs hold their values between done pulses.
- start while busy is ignored: no queueing and no effect on the conversion in progress.
- hex_in changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, binary_out=0, bcd_out=0, octal_out=0, overflow=0, internal registers 0.
- Accept edge = cycle 0. SHIFT occupies cycles 1..WIDTH. done=1 in cycle WIDTH+1, with outputs updated on the same edge.
- Latency is WIDTH+1 cycles from the accepting edge to done. ready returns in cycle WIDTH+2.
- Throughput is one conversion per WIDTH+2 cycles. Back-to-back starts are accepted on the first ready cycle.
- rst mid-conversion: the conversion is aborted, no done is issued, and all outputs return to their reset values on the next edge.
- rst and start asserted together: rst wins and start is dropped.

## Configuration
- Macro OCTAL_OUT_EN.
- Defined: octal regroup logic is built and octal_out is updated in DONE as specified.
- Undefined: octal logic is omitted; octal_out is present but tied to 0 at all times. All other behaviour and timing are unchanged.

## Test plan
- Reset, then HEX_DIGITS=4, DEC_DIGITS=5, start with hex_in=16'hFFFF -> done exactly 17 cycles after accept; bcd_out=20'h65535, octal_out=18'o177777, binary_out=16'hFFFF, overflow=0.
- hex_in=16'h0000 and 16'h00FF -> bcd_out 20'h00000 / 20'h00255; octal_out 0 / 18'o000377.
- DEC_DIGITS=4: hex_in=16'h270F -> bcd_out=16'h9999, overflow=0. hex_in=16'h2710 -> bcd_out=16'h9999, overflow=1, binary_out=16'h2710.
- Accept 16'h1234, pulse start with 16'hABCD in cycle 5 -> ignored; done gives bcd_out=20'h04660. A start on the first ready cycle is then accepted.
- Assert rst in cycle 8 of a conversion -> no done pulse; all outputs 0 and ready=1 on the next cycle.
- Build without OCTAL_OUT_EN, convert 16'hFFFF -> octal_out=0; bcd_out and timing identical to the first scenario.
